// File: rtl/key_pkg.sv
// Shared types and timing helpers for the key click decoder slice.
package key_pkg;

    // Collector state: waiting for a first press, or counting presses of a group.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } key_state_e;

    localparam int unsigned CLK_HZ = 50_000_000;

    // Convert a duration in milliseconds into clk cycles at CLK_HZ.
    function automatic int unsigned ms2cyc(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage : key_pkg

// File: rtl/key_click_decoder_if.sv
// Click event output channel: valid/ready slot plus a drop pulse.
//  evt_valid   event available (producer)
//  evt_ready   consumer accepts when evt_valid && evt_ready at clk edge
//  evt_clicks  press count of the held event (producer)
//  evt_drop    one-cycle pulse, completed event discarded (producer)
interface key_click_decoder_if #(
    parameter int unsigned CLICK_W = 2
) ();

    logic               evt_valid;
    logic               evt_ready;
    logic [CLICK_W-1:0] evt_clicks;
    logic               evt_drop;

    modport master (
        output evt_valid,
        output evt_clicks,
        output evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_clicks,
        input  evt_drop,
        output evt_ready
    );

endinterface : key_click_decoder_if

// File: rtl/key_evt_slot.sv
// Single-entry valid/ready holding register for completed click events.
//  clk, rst_n   clock, async active-low reset
//  emit         a group completed this cycle
//  emit_clicks  press count of the completed group
//  evt          event channel (master side): evt_valid, evt_clicks, evt_drop out; evt_ready in
module key_evt_slot #(
    parameter int unsigned CLICK_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               emit,
    input  logic [CLICK_W-1:0] emit_clicks,
    key_click_decoder_if.master evt
);

    logic drain_c;

    // The slot frees up at this edge if the held event is being accepted.
    assign drain_c = evt.evt_valid && evt.evt_ready;

    // Hold one event; load on emit when empty or draining, otherwise flag a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt.evt_valid  <= 1'b0;
            evt.evt_clicks <= '0;
            evt.evt_drop   <= 1'b0;
        end else begin
            evt.evt_drop <= 1'b0;
            if (emit) begin
                if (!evt.evt_valid || drain_c) begin
                    evt.evt_valid  <= 1'b1;
                    evt.evt_clicks <= emit_clicks;
                end else begin
                    evt.evt_drop <= 1'b1;
                end
            end else if (drain_c) begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

endmodule : key_evt_slot

// File: rtl/key_click_decoder.sv
// Groups debounced press strobes closer than WINDOW_CYC cycles into click events
// (single, double, ... up to MAX_CLICKS) and hands them to a valid/ready slot.
//  clk, rst_n   clock, async active-low reset
//  key_press    one-cycle press strobe from the debouncer
//  evt          event channel (master side): evt_valid, evt_clicks, evt_drop out; evt_ready in
module key_click_decoder
    import key_pkg::*;
#(
    parameter int unsigned WINDOW_CYC = ms2cyc(300),
    parameter int unsigned MAX_CLICKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_press,
    key_click_decoder_if.master evt
);

    localparam int unsigned CLICK_W = $clog2(MAX_CLICKS + 1);
    localparam int unsigned TMR_W   = $clog2(WINDOW_CYC);

    key_state_e         state_q, state_d;
    logic [CLICK_W-1:0] count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               emit_c;
    logic [CLICK_W-1:0] emit_clicks_c;

    // Collector state, press count and inter-press timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic; a press in the timeout cycle restarts the window instead of emitting.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        timer_d       = '0;
        emit_c        = 1'b0;
        emit_clicks_c = count_q;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (key_press) begin
                    state_d = COLLECT;
                    count_d = CLICK_W'(1);
                end
            end
            COLLECT: begin
                timer_d = timer_q + TMR_W'(1);
                if (key_press) begin
                    if ((count_q + CLICK_W'(1)) == CLICK_W'(MAX_CLICKS)) begin
                        emit_c        = 1'b1;
                        emit_clicks_c = CLICK_W'(MAX_CLICKS);
                        state_d       = IDLE;
                        count_d       = '0;
                        timer_d       = '0;
                    end else begin
                        count_d = count_q + CLICK_W'(1);
                        timer_d = '0;
                    end
                end else if (timer_q == TMR_W'(WINDOW_CYC - 1)) begin
                    emit_c        = 1'b1;
                    emit_clicks_c = count_q;
                    state_d       = IDLE;
                    count_d       = '0;
                    timer_d       = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    key_evt_slot #(
        .CLICK_W (CLICK_W)
    ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .emit        (emit_c),
        .emit_clicks (emit_clicks_c),
        .evt         (evt)
    );

endmodule : key_click_decoder

// File: tb/tb_key_click_decoder.sv
// Randomized and directed bench for key_click_decoder against a press-time reference model.
module tb_key_click_decoder;

    localparam int unsigned WIN  = 8;
    localparam int unsigned MAXC = 3;
    localparam int unsigned CW   = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic key_press;

    always #5 clk = ~clk;

    key_click_decoder_if #(.CLICK_W(CW)) evt_if ();

    key_click_decoder #(
        .WINDOW_CYC (WIN),
        .MAX_CLICKS (MAXC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_press (key_press),
        .evt       (evt_if)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: group tracked by press count and the edge number of its last press.
    int edge_no   = 0;
    bit in_grp    = 1'b0;
    int grp_n     = 0;
    int last_edge = 0;
    bit m_valid   = 1'b0;
    int m_clicks  = 0;
    bit m_drop    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        in_grp   = 1'b0;
        grp_n    = 0;
        m_valid  = 1'b0;
        m_clicks = 0;
        m_drop   = 1'b0;
    endfunction

    // Advance the model by one clk edge with the inputs sampled at that edge.
    function automatic void model_edge(input bit p, input bit r);
        int  done_n;
        bit  drain;
        edge_no++;
        done_n = 0;
        if (p) begin
            if (!in_grp) begin
                in_grp    = 1'b1;
                grp_n     = 1;
                last_edge = edge_no;
            end else if (grp_n + 1 == int'(MAXC)) begin
                done_n = int'(MAXC);
                in_grp = 1'b0;
            end else begin
                grp_n++;
                last_edge = edge_no;
            end
        end else if (in_grp && (edge_no - last_edge) == int'(WIN)) begin
            done_n = grp_n;
            in_grp = 1'b0;
        end
        drain  = m_valid && r;
        m_drop = 1'b0;
        if (done_n != 0) begin
            if (!m_valid || drain) begin
                m_valid  = 1'b1;
                m_clicks = done_n;
            end else begin
                m_drop = 1'b1;
            end
        end else if (drain) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_valid"},  32'(evt_if.evt_valid),  32'(m_valid));
        check({tag, "_clicks"}, 32'(evt_if.evt_clicks), 32'(m_clicks));
        check({tag, "_drop"},   32'(evt_if.evt_drop),   32'(m_drop));
    endtask

    // One clock: drive inputs, take the edge, update the model, compare 1 time unit later.
    task automatic step(input string tag, input bit p, input bit r);
        key_press        = p;
        evt_if.evt_ready = r;
        @(posedge clk);
        model_edge(p, r);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n, input bit r);
        for (int i = 0; i < n; i++) step(tag, 1'b0, r);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n     = 1'b0;
        key_press = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("rst_release");
    endtask

    initial begin
        rst_n            = 1'b0;
        key_press        = 1'b0;
        evt_if.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid",  32'(evt_if.evt_valid),  32'd0);
        check("reset_clicks", 32'(evt_if.evt_clicks), 32'd0);
        check("reset_drop",   32'(evt_if.evt_drop),   32'd0);
        rst_n = 1'b1;

        // Single press: event only after the full window.
        idle("s1", 3, 1'b1);
        step("s1_press", 1'b1, 1'b1);
        idle("s1", 7, 1'b1);
        check("s1_before_window", 32'(evt_if.evt_valid), 32'd0);
        step("s1_emit", 1'b0, 1'b1);
        check("s1_valid", 32'(evt_if.evt_valid), 32'd1);
        check("s1_clicks", 32'(evt_if.evt_clicks), 32'd1);
        idle("s1", 4, 1'b1);

        // Double press four cycles apart.
        step("s2_p1", 1'b1, 1'b1);
        idle("s2", 3, 1'b1);
        step("s2_p2", 1'b1, 1'b1);
        idle("s2", 8, 1'b1);
        check("s2_clicks", 32'(evt_if.evt_clicks), 32'd2);
        idle("s2", 4, 1'b1);

        // Triple press closes immediately.
        step("s3_p1", 1'b1, 1'b1);
        step("s3", 1'b0, 1'b1);
        step("s3_p2", 1'b1, 1'b1);
        step("s3", 1'b0, 1'b1);
        step("s3_p3", 1'b1, 1'b1);
        check("s3_valid", 32'(evt_if.evt_valid), 32'd1);
        check("s3_clicks", 32'(evt_if.evt_clicks), 32'd3);
        idle("s3", 12, 1'b1);

        // Press coinciding with the timeout cycle extends the group.
        step("s4_p1", 1'b1, 1'b1);
        idle("s4", 7, 1'b1);
        step("s4_p2", 1'b1, 1'b1);
        check("s4_no_emit", 32'(evt_if.evt_valid), 32'd0);
        idle("s4", 8, 1'b1);
        check("s4_clicks", 32'(evt_if.evt_clicks), 32'd2);
        idle("s4", 4, 1'b1);

        // Slot held with ready low: second event is dropped, held event unchanged.
        step("s5_p1", 1'b1, 1'b0);
        idle("s5", 19, 1'b0);
        step("s5_p2", 1'b1, 1'b0);
        idle("s5", 8, 1'b0);
        check("s5_drop", 32'(evt_if.evt_drop), 32'd1);
        check("s5_held", 32'(evt_if.evt_clicks), 32'd1);
        step("s5_drain", 1'b0, 1'b1);
        check("s5_drained", 32'(evt_if.evt_valid), 32'd0);
        idle("s5", 3, 1'b1);

        // Reset mid-group discards everything.
        step("s6_p1", 1'b1, 1'b1);
        idle("s6", 2, 1'b1);
        apply_reset(2);
        idle("s6_post", 20, 1'b1);
        check("s6_quiet", 32'(evt_if.evt_valid), 32'd0);

        // Random traffic with occasional resets.
        begin
            bit prev_p = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                bit p;
                bit r;
                if ($urandom_range(0, 499) == 0) begin
                    apply_reset(int'($urandom_range(1, 3)));
                    prev_p = 1'b0;
                end
                p = !prev_p && ($urandom_range(0, 5) == 0);
                r = ($urandom_range(0, 9) < 6);
                step("rnd", p, r);
                prev_p = p;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_key_click_decoder
